pos_tracker: RTL and testbench

- Parametrised left/right position tracker for the front-panel pushbuttons.
- Two raw direction inputs are edge-qualified so that one press moves one step.
- A signed position is kept in -RANGE..+RANGE, saturating at the ends.
- A hold-alarm asserts when the user keeps pushing against a saturated end; feeds the display and annunciator logic.

---
 rtl/pos_tracker_pkg.sv | 14 +
 rtl/edge_pulse.sv | 18 +
 rtl/pos_tracker.sv | 126 ++++++++++++
 tb/tb_pos_tracker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pos_tracker_pkg.sv
// Shared types and helpers for the pos_tracker pushbutton position tracker.
package pos_tracker_pkg;

  typedef enum logic [1:0] {
    ARM   = 2'b00,
    COUNT = 2'b01,
    ALARM = 2'b10
  } alarm_state_t;

  function automatic int pos_w_calc(input int range);
    return $clog2(range + 1) + 1;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge qualifier: a single-cycle pulse on the first sampled-high cycle of a.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic a,
  output logic y
);

  logic r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_q <= 1'b0;
    else        r_q <= a;
  end

  assign y = a & ~r_q;

endmodule

// File: rtl/pos_tracker.sv
// Left/right saturating position tracker with a push-against-end hold alarm.
// Define POS_TRACKER_WRAP_EN to wrap at the ends instead (alarm then tied low).
module pos_tracker
  import pos_tracker_pkg::*;
#(
  parameter  int RANGE       = 3,
  parameter  int HOLD_CYCLES = 4,
  localparam int POS_W       = pos_w_calc(RANGE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    l_in,
  input  logic                    r_in,
  output logic signed [POS_W-1:0] pos,
  output logic                    at_left,
  output logic                    at_right,
  output logic                    step,
  output logic                    alarm
);

  localparam logic signed [POS_W-1:0] P_MAX = POS_W'(RANGE);
  localparam logic signed [POS_W-1:0] P_MIN = -P_MAX;
  localparam logic signed [POS_W-1:0] P_ONE = POS_W'(1);

  logic                    w_lp, w_rp;
  logic signed [POS_W-1:0] r_pos, w_next;
  logic                    r_step;

  edge_pulse u_left  (.clk(clk), .reset(reset), .a(l_in), .y(w_lp));
  edge_pulse u_right (.clk(clk), .reset(reset), .a(r_in), .y(w_rp));

  assign at_left  = (r_pos == P_MIN);
  assign at_right = (r_pos == P_MAX);

  always_comb begin
    w_next = r_pos;
    if (w_lp && !w_rp) begin
`ifdef POS_TRACKER_WRAP_EN
      w_next = at_left ? P_MAX : r_pos - P_ONE;
`else
      w_next = at_left ? r_pos : r_pos - P_ONE;
`endif
    end else if (w_rp && !w_lp) begin
`ifdef POS_TRACKER_WRAP_EN
      w_next = at_right ? P_MIN : r_pos + P_ONE;
`else
      w_next = at_right ? r_pos : r_pos + P_ONE;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos  <= '0;
      r_step <= 1'b0;
    end else begin
      r_pos  <= w_next;
      r_step <= (w_next != r_pos);
    end
  end

  assign pos  = r_pos;
  assign step = r_step;

`ifdef POS_TRACKER_WRAP_EN
  assign alarm = 1'b0;
`else
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic          w_push;
  alarm_state_t  r_state;
  logic [CW-1:0] r_cnt;
  logic          r_alarm;

  // Level-based: holding a button against the end counts every cycle, not just the pulse.
  assign w_push = (at_left & l_in & ~r_in) | (at_right & r_in & ~l_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARM;
      r_cnt   <= '0;
      r_alarm <= 1'b0;
    end else begin
      case (r_state)
        ARM: begin
          if (w_push) begin
            r_cnt <= CW'(1);
            if (HOLD_CYCLES == 1) begin
              r_state <= ALARM;
              r_alarm <= 1'b1;
            end else begin
              r_state <= COUNT;
            end
          end
        end
        COUNT: begin
          if (!w_push) begin
            r_state <= ARM;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
            r_state <= ALARM;
            r_alarm <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ALARM: begin
          if (!w_push) begin
            r_state <= ARM;
            r_cnt   <= '0;
            r_alarm <= 1'b0;
          end
        end
        default: begin
          r_state <= ARM;
          r_cnt   <= '0;
          r_alarm <= 1'b0;
        end
      endcase
    end
  end

  assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_pos_tracker.sv
// Self-checking bench for pos_tracker (RANGE=3, HOLD_CYCLES=4); follows POS_TRACKER_WRAP_EN.
module tb_pos_tracker;

  localparam int RANGE = 3;
  localparam int HOLD  = 4;
  localparam int POS_W = $clog2(RANGE + 1) + 1;
`ifdef POS_TRACKER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    l_in = 1'b0;
  logic                    r_in = 1'b0;
  logic signed [POS_W-1:0] pos;
  logic                    at_left, at_right, step, alarm;

  pos_tracker #(.RANGE(RANGE), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .l_in(l_in), .r_in(r_in),
    .pos(pos), .at_left(at_left), .at_right(at_right), .step(step), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: position as a plain integer, alarm as "consecutive push cycles >= HOLD".
  int m_pos, m_hold;
  bit m_pl, m_pr, m_step, m_alarm;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_hold = 0; m_pl = 0; m_pr = 0; m_step = 0; m_alarm = 0;
  endtask

  task automatic model_edge(input bit l, input bit r);
    bit lp, rp, push;
    int np;
    lp   = l && !m_pl;
    rp   = r && !m_pr;
    push = (m_pos == -RANGE && l && !r) || (m_pos == RANGE && r && !l);
    np   = m_pos;
    if (lp && !rp) begin
      if (m_pos > -RANGE) np = m_pos - 1;
      else if (WRAP)      np = RANGE;
    end else if (rp && !lp) begin
      if (m_pos < RANGE)  np = m_pos + 1;
      else if (WRAP)      np = -RANGE;
    end
    m_step = (np != m_pos);
    m_pos  = np;
    m_pl   = l;
    m_pr   = r;
    m_hold = push ? m_hold + 1 : 0;
    m_alarm = !WRAP && (m_hold >= HOLD);
  endtask

  task automatic check_model();
    chk("mdl_pos", int'(pos), m_pos);
    chk("mdl_step", int'(step), int'(m_step));
    chk("mdl_alarm", int'(alarm), int'(m_alarm));
    chk("mdl_at_left", int'(at_left), int'(m_pos == -RANGE));
    chk("mdl_at_right", int'(at_right), int'(m_pos == RANGE));
  endtask

  // Drive inputs away from the edge, clock once, then compare just after the edge.
  task automatic cyc(input bit l, input bit r);
    l_in = l;
    r_in = r;
    @(posedge clk);
    model_edge(l, r);
    #1;
    check_model();
  endtask

  // Assert reset mid-cycle and check that outputs clear without any clock edge.
  task automatic do_reset(input string name);
    reset = 1'b0;
    l_in  = 1'b0;
    r_in  = 1'b0;
    #2;
    model_reset();
    chk({name, "_pos"}, int'(pos), 0);
    chk({name, "_step"}, int'(step), 0);
    chk({name, "_alarm"}, int'(alarm), 0);
    reset = 1'b1;
    #1;
  endtask

  typedef struct {
    bit l;
    bit r;
    int exp_pos;
    bit exp_step;
    bit exp_right;
  } vec_t;

  vec_t tbl[10];
  int   steps;

  initial begin
    // Five right presses from reset: saturates at +3 after the third.
    tbl[0] = '{0, 1, 1, 1, 0};
    tbl[1] = '{0, 0, 1, 0, 0};
    tbl[2] = '{0, 1, 2, 1, 0};
    tbl[3] = '{0, 0, 2, 0, 0};
    tbl[4] = '{0, 1, 3, 1, 1};
    tbl[5] = '{0, 0, 3, 0, 1};
    tbl[6] = '{0, 1, WRAP ? -3 : 3, WRAP, !WRAP};
    tbl[7] = '{0, 0, WRAP ? -3 : 3, 0, !WRAP};
    tbl[8] = '{0, 1, WRAP ? -2 : 3, WRAP, !WRAP};
    tbl[9] = '{0, 0, WRAP ? -2 : 3, 0, !WRAP};

    model_reset();
    #12;
    chk("rst_pos", int'(pos), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_alarm", int'(alarm), 0);
    reset = 1'b1;
    #1;

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].l, tbl[i].r);
      chk($sformatf("tbl%0d_pos", i), int'(pos), tbl[i].exp_pos);
      chk($sformatf("tbl%0d_step", i), int'(step), int'(tbl[i].exp_step));
      chk($sformatf("tbl%0d_at_right", i), int'(at_right), int'(tbl[i].exp_right));
    end

`ifndef POS_TRACKER_WRAP_EN
    // Hold right against +3 until alarm, then async reset mid-alarm.
    for (int i = 0; i < HOLD; i++) cyc(0, 1);
    chk("hold_right_alarm", int'(alarm), 1);
    do_reset("rst_mid_alarm");

    // Left held 10 cycles from 0: one step only, no alarm.
    steps = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0);
      steps += int'(step);
      chk("lhold_alarm", int'(alarm), 0);
    end
    chk("lhold_pos", int'(pos), -1);
    chk("lhold_steps", steps, 1);

    // Reach -3, then hold left 6 cycles: alarm on cycles 4..6, drops after release.
    cyc(0, 0); cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
    chk("at_left_reached", int'(at_left), 1);
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 0);
      chk($sformatf("lalarm_c%0d", i), int'(alarm), int'(i >= HOLD));
    end
    cyc(0, 0);
    chk("lalarm_release", int'(alarm), 0);

    // Simultaneous rising edges at 0: no move.
    do_reset("rst_seq_d");
    cyc(1, 1);
    chk("both_pos", int'(pos), 0);
    chk("both_step", int'(step), 0);
    cyc(0, 0);
    // To +3, hold right 2 cycles, then press left while right still held.
    cyc(0, 1); cyc(0, 0); cyc(0, 1); cyc(0, 0); cyc(0, 1);
    cyc(0, 1); cyc(0, 1);
    cyc(1, 1);
    chk("away_pos", int'(pos), 2);
    chk("away_alarm", int'(alarm), 0);
    // Back to +3: a fresh full hold is needed before alarm.
    cyc(0, 0); cyc(0, 1);
    for (int i = 1; i <= HOLD; i++) begin
      cyc(0, 1);
      chk($sformatf("fresh_c%0d", i), int'(alarm), int'(i >= HOLD));
    end
`else
    do_reset("rst_wrap");
    cyc(0, 1); cyc(0, 0); cyc(0, 1); cyc(0, 0); cyc(0, 1); cyc(0, 0);
    chk("wrap_pre_pos", int'(pos), 3);
    cyc(0, 1);
    chk("wrap_pos", int'(pos), -3);
    chk("wrap_step", int'(step), 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1);
      chk("wrap_hold_alarm", int'(alarm), 0);
    end
`endif

    // Randomised traffic with sticky-ish buttons and occasional resets.
    do_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      bit l, r;
      if ($urandom_range(0, 99) == 0) do_reset("rst_rand_mid");
      l = ($urandom_range(0, 99) < 40);
      r = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 3) != 0) begin
        l = m_pl;
        r = m_pr;
      end
      cyc(l, r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
